// File: rtl/add37_share_arb.sv
// Round-robin scheduler sharing one fixed-latency 37-bit pipelined adder among
// NREQ requesters; a valid/owner tag pipeline routes each sum back to its issuer.

module add37_share_arb_lane #(
  parameter int NREQ = 4,
  parameter int PW   = 2,
  parameter int IDX  = 0
) (
  input  logic          tag_vld,
  input  logic [PW-1:0] tag_own,
  output logic          strobe
);
  assign strobe = tag_vld && (tag_own == PW'(IDX));
endmodule

module add37_share_arb #(
  parameter int WIDTH   = 37,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_y,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    hold,
  output logic [WIDTH-1:0]        add_x,
  output logic [WIDTH-1:0]        add_y,
  input  logic [WIDTH-1:0]        add_sum,
  output logic [NREQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]        resp_sum,
  output logic                    busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]              ptr_q, ptr_d;
  logic [PW-1:0]              sel;
  logic                       xfer;
  int                         idx;
  logic [WIDTH-1:0]           add_x_q, add_x_d, add_y_q, add_y_d;
  logic [ADD_LAT:0]           vld_pipe_q, vld_pipe_d;
  logic [ADD_LAT:0][PW-1:0]   own_pipe_q, own_pipe_d;
  logic [NREQ-1:0]            resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]           resp_sum_q, resp_sum_d;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    req_ready = '0;
    sel       = '0;
    xfer      = 1'b0;
    idx       = 0;
    if (!reset && !hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!xfer && req_valid[idx]) begin
          xfer           = 1'b1;
          req_ready[idx] = 1'b1;
          sel            = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    ptr_d   = xfer ? sel : ptr_q;
    add_x_d = xfer ? req_x[sel*WIDTH +: WIDTH] : add_x_q;
    add_y_d = xfer ? req_y[sel*WIDTH +: WIDTH] : add_y_q;
    // The adder never stalls, so tags shift every cycle; the last stage lines
    // up with add_sum for the operation issued ADD_LAT+1 cycles earlier.
    vld_pipe_d = {vld_pipe_q[ADD_LAT-1:0], xfer};
    own_pipe_d = {own_pipe_q[ADD_LAT-1:0], sel};
    resp_sum_d = vld_pipe_q[ADD_LAT] ? add_sum : resp_sum_q;
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    add37_share_arb_lane #(.NREQ(NREQ), .PW(PW), .IDX(i)) u_lane (
      .tag_vld (vld_pipe_q[ADD_LAT]),
      .tag_own (own_pipe_q[ADD_LAT]),
      .strobe  (resp_valid_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= PW'(NREQ-1);
      add_x_q      <= '0;
      add_y_q      <= '0;
      vld_pipe_q   <= '0;
      own_pipe_q   <= '0;
      resp_valid_q <= '0;
      resp_sum_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      add_x_q      <= add_x_d;
      add_y_q      <= add_y_d;
      vld_pipe_q   <= vld_pipe_d;
      own_pipe_q   <= own_pipe_d;
      resp_valid_q <= resp_valid_d;
      resp_sum_q   <= resp_sum_d;
    end
  end

  assign add_x      = add_x_q;
  assign add_y      = add_y_q;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign busy       = (|vld_pipe_q) || (|resp_valid_q);
endmodule

// File: tb/tb_add37_share_arb.sv
// Directed bench for add37_share_arb with a 5-stage behavioural adder model.

module tb_add37_share_arb;
  localparam int W = 37;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_x, req_y;
  logic [N-1:0]     req_ready;
  logic             hold;
  logic [W-1:0]     add_x, add_y, add_sum;
  logic [N-1:0]     resp_valid;
  logic [W-1:0]     resp_sum;
  logic             busy;

  int checks = 0;
  int errors = 0;

  add37_share_arb #(.WIDTH(W), .NREQ(N), .ADD_LAT(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .hold(hold), .add_x(add_x), .add_y(add_y),
    .add_sum(add_sum), .resp_valid(resp_valid), .resp_sum(resp_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared adder: operands sampled each edge, sum appears 5 edges later.
  logic [W-1:0] apipe [5];
  initial for (int i = 0; i < 5; i++) apipe[i] = '0;
  always @(posedge clk) begin
    apipe[0] <= add_x + add_y;
    for (int i = 1; i < 5; i++) apipe[i] <= apipe[i-1];
  end
  assign add_sum = apipe[4];

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_single(input int r, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] s);
    req_x[r*W +: W] = x;
    req_y[r*W +: W] = y;
    req_valid = N'(1 << r);
    mid(); chk("single_grant", 64'(req_ready), 64'(1 << r));
    next(); req_valid = '0;
    mid(); chk("single_add_x", 64'(add_x), 64'(x));
    chk("single_add_y", 64'(add_y), 64'(y));
    chk("single_busy", 64'(busy), 64'd1);
    for (int k = 2; k <= 6; k++) begin
      next(); mid(); chk("single_early", 64'(resp_valid), 64'd0);
    end
    next(); mid();
    chk("single_resp_valid", 64'(resp_valid), 64'(1 << r));
    chk("single_resp_sum", 64'(resp_sum), 64'(s));
    chk("single_resp_busy", 64'(busy), 64'd1);
    next(); mid();
    chk("single_pulse_end", 64'(resp_valid), 64'd0);
    chk("single_idle", 64'(busy), 64'd0);
    next();
  endtask

  initial begin
    int opi;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    logic [W-1:0] es;
    reset = 1'b1; hold = 1'b0; req_valid = '0; req_x = '0; req_y = '0;

    repeat (2) next();
    req_valid = '1;
    mid();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_add_x", 64'(add_x), 64'd0);
    chk("rst_add_y", 64'(add_y), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_sum", 64'(resp_sum), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    next(); reset = 1'b0; req_valid = '0;
    repeat (2) next();

    run_single(0, 37'd1, 37'd2, 37'd3);
    run_single(2, 37'h00_0000_01FF, 37'd1, 37'h200);
    run_single(2, 37'h1F_FFFF_FFFF, 37'd1, 37'd0);

    // Fairness: req 3 alone, then 0 and 3 together -> 0 first, then 3.
    req_x[3*W +: W] = 37'd5; req_y[3*W +: W] = 37'd6;
    req_x[0*W +: W] = 37'd7; req_y[0*W +: W] = 37'd8;
    for (int t = 0; t <= 10; t++) begin
      case (t)
        0: req_valid = 4'b1000;
        1: req_valid = 4'b1001;
        2: req_valid = 4'b1000;
        default: req_valid = 4'b0000;
      endcase
      er = (t == 1) ? 4'b0001 : (t == 0 || t == 2) ? 4'b1000 : 4'b0000;
      ev = (t == 8) ? 4'b0001 : (t == 7 || t == 9) ? 4'b1000 : 4'b0000;
      es = (t == 8) ? 37'd15 : 37'd11;
      mid();
      chk("fair_ready", 64'(req_ready), 64'(er));
      chk("fair_resp_valid", 64'(resp_valid), 64'(ev));
      if (ev != 0) chk("fair_resp_sum", 64'(resp_sum), 64'(es));
      if (t == 10) chk("fair_idle", 64'(busy), 64'd0);
      next();
    end

    // Full contention: requester i sends x=i+1, y=100 for 8 cycles.
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = W'(i + 1);
      req_y[i*W +: W] = 37'd100;
    end
    req_valid = '1;
    for (int k = 0; k <= 15; k++) begin
      mid();
      chk("cont_ready", 64'(req_ready), (k < 8) ? 64'(1 << (k % 4)) : 64'd0);
      if (k >= 7 && k <= 14) begin
        chk("cont_resp_valid", 64'(resp_valid), 64'(1 << ((k - 7) % 4)));
        chk("cont_resp_sum", 64'(resp_sum), 64'(101 + ((k - 7) % 4)));
      end else begin
        chk("cont_resp_idle", 64'(resp_valid), 64'd0);
      end
      if (k == 15) chk("cont_drained", 64'(busy), 64'd0);
      next();
      if (k == 7) req_valid = '0;
    end

    // hold for 3 cycles after the 2nd of 4 back-to-back ops from req 1.
    opi = 0;
    for (int t = 0; t <= 14; t++) begin
      hold = (t >= 2 && t <= 4);
      req_valid = (t <= 6) ? 4'b0010 : 4'b0000;
      req_x[1*W +: W] = W'(10 + opi);
      req_y[1*W +: W] = 37'd1000;
      er = (t == 0 || t == 1 || t == 5 || t == 6) ? 4'b0010 : 4'b0000;
      case (t)
        7:  begin ev = 4'b0010; es = 37'd1010; end
        8:  begin ev = 4'b0010; es = 37'd1011; end
        12: begin ev = 4'b0010; es = 37'd1012; end
        13: begin ev = 4'b0010; es = 37'd1013; end
        default: begin ev = 4'b0000; es = '0; end
      endcase
      mid();
      chk("hold_ready", 64'(req_ready), 64'(er));
      chk("hold_resp_valid", 64'(resp_valid), 64'(ev));
      if (ev != 0) chk("hold_resp_sum", 64'(resp_sum), 64'(es));
      if (er != 0) opi++;
      next();
    end
    hold = 1'b0; req_valid = '0;

    // Reset while three ops are in flight.
    req_y[0*W +: W] = 37'd1;
    for (int t = 0; t <= 12; t++) begin
      reset = (t == 4);
      req_valid = (t <= 2 || t == 4) ? 4'b0001 : 4'b0000;
      req_x[0*W +: W] = W'(1 + t);
      mid();
      if (t <= 2) chk("rstm_grant", 64'(req_ready), 64'd1);
      if (t == 3) chk("rstm_busy_before", 64'(busy), 64'd1);
      if (t == 4) chk("rstm_ready_in_reset", 64'(req_ready), 64'd0);
      if (t == 5) begin
        chk("rstm_busy_after", 64'(busy), 64'd0);
        chk("rstm_add_x", 64'(add_x), 64'd0);
      end
      if (t >= 5) chk("rstm_no_resp", 64'(resp_valid), 64'd0);
      next();
    end
    reset = 1'b0; req_valid = '0;

    run_single(0, 37'd20, 37'd22, 37'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
